// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue, writeback and status signals of the register scoreboard
interface reg_scoreboard_if #(
   parameter int NUM_REGS    = 14,
   parameter int STALL_CNT_W = 16
);
   logic                   issue_valid;
   logic [3:0]             issue_src1;
   logic [3:0]             issue_src2;
   logic                   issue_two_src;
   logic                   issue_wb_en;
   logic [3:0]             issue_dest;
   logic                   issue_stall;
   logic                   wb_en;
   logic [3:0]             wb_dest;
   logic                   flush;
   logic [NUM_REGS-1:0]    pending_mask;
   logic                   err_underflow;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output issue_valid, issue_src1, issue_src2, issue_two_src, issue_wb_en, issue_dest,
      output wb_en, wb_dest, flush,
      input  issue_stall, pending_mask, err_underflow, stall_cycles
   );

   modport slave (
      input  issue_valid, issue_src1, issue_src2, issue_two_src, issue_wb_en, issue_dest,
      input  wb_en, wb_dest, flush,
      output issue_stall, pending_mask, err_underflow, stall_cycles
   );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters with RAW/WAW-overflow stall
module reg_scoreboard #(
   parameter int NUM_REGS    = 14,
   parameter int CNT_W       = 2,
   parameter int STALL_CNT_W = 16
) (
   input logic             clk,
   input logic             rst,
   reg_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]       cnt [NUM_REGS];
   logic [CNT_W-1:0]       c_src1, c_src2, c_dest, c_wb;
   logic [NUM_REGS-1:0]    inc_vec, dec_vec, pend;
   logic                   dest_trk, wb_trk;
   logic                   src1_haz, src2_haz, dest_full;
   logic                   stall, accept, wb_underflow;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   err_q;

   // Untracked indices never match a counter, so they read back as count 0.
   always_comb begin
      c_src1 = '0;
      c_src2 = '0;
      c_dest = '0;
      c_wb   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sb.issue_src1 == 4'(i)) c_src1 = cnt[i];
         if (sb.issue_src2 == 4'(i)) c_src2 = cnt[i];
         if (sb.issue_dest == 4'(i)) c_dest = cnt[i];
         if (sb.wb_dest    == 4'(i)) c_wb   = cnt[i];
      end
   end

   assign dest_trk = {1'b0, sb.issue_dest} < 5'(NUM_REGS);
   assign wb_trk   = {1'b0, sb.wb_dest}    < 5'(NUM_REGS);

   // A last pending write retiring this cycle lands before the operand read.
   assign src1_haz = (c_src1 != '0) &&
                     !(sb.wb_en && sb.wb_dest == sb.issue_src1 && c_src1 == CNT_W'(1));
   assign src2_haz = (c_src2 != '0) &&
                     !(sb.wb_en && sb.wb_dest == sb.issue_src2 && c_src2 == CNT_W'(1));
   assign dest_full = sb.issue_wb_en && dest_trk && (c_dest == CNT_MAX) &&
                      !(sb.wb_en && sb.wb_dest == sb.issue_dest);

   assign stall        = sb.issue_valid && (src1_haz || (sb.issue_two_src && src2_haz) || dest_full);
   assign accept       = sb.issue_valid && !stall && !sb.flush;
   assign wb_underflow = sb.wb_en && wb_trk && (c_wb == '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      pend    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         inc_vec[i] = accept && sb.issue_wb_en && (sb.issue_dest == 4'(i));
         dec_vec[i] = sb.wb_en && (sb.wb_dest == 4'(i)) && (cnt[i] != '0);
         pend[i]    = (cnt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
         err_q     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
         if (sb.flush) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
         end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + CNT_W'(1);
               else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (wb_underflow) err_q <= 1'b1;
         end
      end
   end

   assign sb.issue_stall   = stall;
   assign sb.pending_mask  = pend;
   assign sb.err_underflow = err_q;
   assign sb.stall_cycles  = stall_cnt;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - vector table with post-edge expectation queue for reg_scoreboard
module tb_reg_scoreboard;
   typedef struct {
      logic        rst;
      logic        valid;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic        two;
      logic        iwb;
      logic [3:0]  dest;
      logic        wb_en;
      logic [3:0]  wb_dest;
      logic        flush;
      logic        exp_stall;
      logic [13:0] exp_mask;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [13:0] mask;
      logic        err;
      logic [15:0] sc;
      int          row;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   reg_scoreboard_if #(.NUM_REGS(14), .STALL_CNT_W(16)) sb_if ();

   reg_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic v, logic [3:0] s1, logic [3:0] s2, logic two,
                               logic iwb, logic [3:0] d, logic we, logic [3:0] wd, logic fl,
                               logic es, logic [13:0] em, logic ee);
      vec_t x;
      x.rst = r;  x.valid = v;  x.src1 = s1;  x.src2 = s2;  x.two = two;  x.iwb = iwb;
      x.dest = d; x.wb_en = we; x.wb_dest = wd; x.flush = fl;
      x.exp_stall = es; x.exp_mask = em; x.exp_err = ee;
      return x;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      rst                 = v.rst;
      sb_if.issue_valid   = v.valid;
      sb_if.issue_src1    = v.src1;
      sb_if.issue_src2    = v.src2;
      sb_if.issue_two_src = v.two;
      sb_if.issue_wb_en   = v.iwb;
      sb_if.issue_dest    = v.dest;
      sb_if.wb_en         = v.wb_en;
      sb_if.wb_dest       = v.wb_dest;
      sb_if.flush         = v.flush;
   endtask

   initial begin
      logic [15:0] exp_sc;
      vec_t        rv;
      exp_t        e;

      // mk(rst, valid, src1, src2, two_src, issue_wb_en, dest, wb_en, wb_dest, flush, stall, mask, err)
      vecs.push_back(mk(1, 1,  3,  0, 0, 0,  0, 0,  0, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  5, 0,  0, 0, 0, 14'h0020, 0));
      vecs.push_back(mk(1, 1,  5,  0, 0, 0,  0, 0,  0, 0, 1, 14'h0020, 0));
      vecs.push_back(mk(1, 1,  5,  0, 0, 0,  0, 0,  0, 0, 1, 14'h0020, 0));
      vecs.push_back(mk(1, 1,  5,  0, 0, 0,  0, 1,  5, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  2, 0,  0, 0, 0, 14'h0004, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  2, 0,  0, 0, 0, 14'h0004, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  2, 0,  0, 0, 0, 14'h0004, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  2, 0,  0, 0, 1, 14'h0004, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  2, 1,  2, 0, 0, 14'h0004, 0));
      vecs.push_back(mk(1, 1,  2,  0, 0, 0,  0, 1,  2, 0, 1, 14'h0004, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1,  2, 0, 0, 14'h0004, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1,  2, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1, 14, 0,  0, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1, 15, 14, 1, 0,  0, 0,  0, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  7, 0,  0, 0, 0, 14'h0080, 0));
      vecs.push_back(mk(1, 1,  0,  7, 0, 0,  0, 0,  0, 0, 0, 14'h0080, 0));
      vecs.push_back(mk(1, 1,  0,  7, 1, 0,  0, 0,  0, 0, 1, 14'h0080, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1, 15, 0, 0, 14'h0080, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1,  7, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1,  9, 0, 0, 14'h0000, 1));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 14'h0000, 1));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  1, 0,  0, 0, 0, 14'h0002, 1));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  4, 0,  0, 0, 0, 14'h0012, 1));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1, 13, 0,  0, 0, 0, 14'h2012, 1));
      vecs.push_back(mk(1, 1, 13,  0, 0, 1,  6, 1,  0, 1, 1, 14'h0000, 1));
      vecs.push_back(mk(1, 1, 13,  0, 0, 0,  0, 0,  0, 0, 0, 14'h0000, 1));
      vecs.push_back(mk(1, 1,  0,  0, 0, 1,  3, 0,  0, 0, 0, 14'h0008, 1));
      vecs.push_back(mk(0, 1,  0,  0, 0, 1,  5, 1,  9, 0, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 1,  0,  0, 0, 0,  0, 1,  9, 1, 0, 14'h0000, 0));
      vecs.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1,  9, 0, 0, 14'h0000, 1));

      // Reset held for two cycles under random stimulus.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rv = mk(0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 0, 14'h0, 0);
         drive(rv);
         @(posedge clk);
      end
      #1;
      chk("reset_mask",  -1, 32'(sb_if.pending_mask),  32'h0);
      chk("reset_err",   -1, 32'(sb_if.err_underflow), 32'h0);
      chk("reset_stall_cycles", -1, 32'(sb_if.stall_cycles), 32'h0);

      exp_sc = 16'h0;
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         drive(vecs[r]);
         #1;
         chk("issue_stall", r, 32'(sb_if.issue_stall), 32'(vecs[r].exp_stall));
         if (!vecs[r].rst) exp_sc = 16'h0;
         else if (vecs[r].valid && vecs[r].exp_stall && exp_sc != 16'hffff) exp_sc = exp_sc + 16'h1;
         e.mask = vecs[r].exp_mask;
         e.err  = vecs[r].exp_err;
         e.sc   = exp_sc;
         e.row  = r;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            chk("queue_empty", r, 32'h0, 32'h1);
         end else begin
            e = exp_q.pop_front();
            chk("pending_mask",  e.row, 32'(sb_if.pending_mask),  32'(e.mask));
            chk("err_underflow", e.row, 32'(sb_if.err_underflow), 32'(e.err));
            chk("stall_cycles",  e.row, 32'(sb_if.stall_cycles),  32'(e.sc));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Hazard-tracking controller for the 14-entry, 32-bit register file (indices 0..13) that sits between decode/issue and the writeback stage. It counts outstanding writes per register and asserts a stall to issue while any source operand has a write still in flight. Indices 14 and 15 are outside the file and are never tracked. Stall cycles are counted for performance readout.

Parameters:
NUM_REGS, 14, number of tracked registers (indices 0..NUM_REGS-1)
CNT_W, 2, width of per-register pending counter; max outstanding writes = 2^CNT_W-1
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
issue_valid  input  1  decode presents an instruction this cycle
issue_src1  input  4  first source register index
issue_src2  input  4  second source register index
issue_two_src  input  1  1 = src2 is used; 0 = ignore src2
issue_wb_en  input  1  instruction will write back a register
issue_dest  input  4  destination register index
issue_stall  output  1  hold decode; instruction not accepted this cycle
wb_en  input  1  writeback stage writes the register file this cycle
wb_dest  input  4  writeback destination index
flush  input  1  pipeline flush; drop all pending state
pending_mask  output  14  bit i = 1 when register i has count > 0
err_underflow  output  1  sticky: writeback arrived for a register with count 0
stall_cycles  output  STALL_CNT_W  saturating count of cycles with issue_valid && issue_stall

Behaviour:
- Reset (rst=0 at rising edge): all counters, err_underflow and stall_cycles go to 0; pending_mask=0. Reset has priority over flush, issue and wb.
- Tracked index: idx < NUM_REGS. Untracked indices (14, 15) never cause a stall, never increment and never decrement.
- src_hazard(s): s is tracked, count[s] > 0, and NOT (wb_en && wb_dest==s && count[s]==1). The register file writes on the falling edge, so a source whose last pending write retires this cycle reads the new value and is not stalled.
- issue_stall (combinational) = issue_valid && (src_hazard(src1) || (issue_two_src && src_hazard(src2)) || (issue_wb_en && dest tracked && count[dest]==max && !(wb_en && wb_dest==issue_dest))).
- accept = issue_valid && !issue_stall && !flush.
- Per-register update each cycle, flush=0: inc = accept && issue_wb_en && issue_dest==i; dec = wb_en && wb_dest==i && count[i]>0.
  - inc and dec together: count unchanged.
  - Otherwise count +1 or -1 as flagged.
- wb_en to a tracked register with count 0: count stays 0 and err_underflow sets. It stays set until reset.
- flush=1: all counters clear next edge; the same-cycle issue and wb are ignored; err_underflow is not set; issue_stall is still computed normally.
- stall_cycles increments when issue_valid && issue_stall, also during flush, and saturates at all-ones.
- pending_mask is registered-state derived (no combinational path from inputs); issue_stall has zero-cycle latency.
- Latency: an accepted issue is visible in pending_mask the next cycle; a wb decrement is also visible the next cycle.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random inputs -> pending_mask=0, err_underflow=0, stall_cycles=0. Then rst=1 and issue src1=3, issue_two_src=0 -> issue_stall=0.
- RAW stall: issue dest=5 wb_en accepted; next cycle issue src1=5 -> issue_stall=1 and stall_cycles increments each cycle. Then wb_en wb_dest=5 -> issue_stall=0 in that same cycle, and pending_mask[5]=0 next cycle.
- Saturation: three accepted issues to dest=2 give count=3. A fourth issue to dest=2 -> issue_stall=1. Repeat it with wb_en wb_dest=2 the same cycle -> accepted, count remains 3.
- Untracked and src2 gating: issue dest=14 -> pending_mask unchanged. Issue src1=15 -> no stall. With count[7]=1, src2=7 and issue_two_src=0 -> no stall; with issue_two_src=1 -> stall.
- Underflow and flush: wb_en wb_dest=9 with count 0 -> err_underflow=1 and it stays 1. Set pending on registers 1, 4 and 13, then pulse flush with a simultaneous issue to dest=6 -> pending_mask=0 next cycle and err_underflow still 1.
